// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register configuration block.
package spi_reg_pkg;

  localparam int unsigned FRAME_BITS = 16;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin plus a history flop for edge detection.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_reg_config.sv
// SPI mode-0 slave owning the PWM peripheral's five control registers.
// Optional read-back on cipo is enabled by defining SPI_READBACK_EN.
module spi_reg_config
  import spi_reg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = spi_reg_pkg::FRAME_BITS,
  parameter int unsigned MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic copi_s, copi_rise, copi_fall;
  logic ncs_s, ncs_rise, ncs_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sclk),
    .level (sclk_s),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (copi),
    .level (copi_s),
    .rise  (copi_rise),
    .fall  (copi_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ncs),
    .level (ncs_s),
    .rise  (ncs_rise),
    .fall  (ncs_fall)
  );

  state_e                 state_q, state_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] settle_q;
  logic                   armed_q, armed_d;
  logic                   wr_en;
  logic                   frame_ok;
  logic                   frame_rw;
  logic [6:0]             frame_addr;
  logic [7:0]             frame_data;

  logic [7:0] en_out_lo_q, en_out_hi_q, en_pwm_lo_q, en_pwm_hi_q, duty_q;

  assign frame_rw   = shift_q[FRAME_BITS-1];
  assign frame_addr = shift_q[FRAME_BITS-2 -: 7];
  assign frame_data = shift_q[7:0];
  assign frame_ok   = (cnt_q == CNT_FULL) && frame_rw && (32'(frame_addr) <= MAX_ADDR);

  // settle_q marks when the ncs synchroniser holds real pin data rather than its reset value;
  // a frame may only start after ncs has been seen high, so a frame cut by reset is ignored.
  assign armed_d = armed_q | (settle_q[SYNC_STAGES-1] & ncs_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      settle_q <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      armed_q  <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Level-qualified so a frame whose ncs fell during COMMIT is still picked up.
        if (armed_q && (ncs_fall || !ncs_s)) begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ncs_rise) begin
          state_d = frame_ok ? COMMIT : IDLE;
        end else if (sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
      end
      COMMIT: begin
        wr_en   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out_lo_q <= 8'h00;
      en_out_hi_q <= 8'h00;
      en_pwm_lo_q <= 8'h00;
      en_pwm_hi_q <= 8'h00;
      duty_q      <= 8'h00;
    end else if (wr_en) begin
      case (frame_addr)
        ADDR_EN_OUT_LO: en_out_lo_q <= frame_data;
        ADDR_EN_OUT_HI: en_out_hi_q <= frame_data;
        ADDR_EN_PWM_LO: en_pwm_lo_q <= frame_data;
        ADDR_EN_PWM_HI: en_pwm_hi_q <= frame_data;
        ADDR_DUTY:      duty_q      <= frame_data;
        default: ;
      endcase
    end
  end

  assign en_reg_out_7_0  = en_out_lo_q;
  assign en_reg_out_15_8 = en_out_hi_q;
  assign en_reg_pwm_7_0  = en_pwm_lo_q;
  assign en_reg_pwm_15_8 = en_pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;

`ifdef SPI_READBACK_EN
  logic [7:0] tx_q, tx_d;
  logic [7:0] rd_data;
  logic [6:0] rd_addr;

  // Header is complete once the 8th bit lands; the address is taken from the next shift value.
  assign rd_addr = shift_d[6:0];

  always_comb begin
    rd_data = 8'h00;
    if (32'(rd_addr) <= MAX_ADDR) begin
      case (rd_addr)
        ADDR_EN_OUT_LO: rd_data = en_out_lo_q;
        ADDR_EN_OUT_HI: rd_data = en_out_hi_q;
        ADDR_EN_PWM_LO: rd_data = en_pwm_lo_q;
        ADDR_EN_PWM_HI: rd_data = en_pwm_hi_q;
        ADDR_DUTY:      rd_data = duty_q;
        default:        rd_data = 8'h00;
      endcase
    end
  end

  always_comb begin
    tx_d = tx_q;
    if (ncs_s) begin
      tx_d = 8'h00;
    end else if (state_q == SHIFT && sclk_rise && !ncs_rise &&
                 cnt_q == CNT_W'(FRAME_BITS - 9) && !shift_d[7]) begin
      tx_d = rd_data;
    end else if (state_q == SHIFT && sclk_fall &&
                 cnt_q > CNT_W'(FRAME_BITS - 8) && cnt_q < CNT_FULL) begin
      tx_d = {tx_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_q <= 8'h00;
    else        tx_q <= tx_d;
  end

  assign cipo = tx_q[7] & ~ncs_s;

  logic unused_edges;
  assign unused_edges = ^{copi_rise, copi_fall, sclk_s};
`else
  assign cipo = 1'b0;

  logic unused_edges;
  assign unused_edges = ^{copi_rise, copi_fall, sclk_s, sclk_fall};
`endif

endmodule
